ram_access_arb: RTL and testbench
=================================

Name: ram_access_arb

Overview:
Clock-domain controller and arbiter for the 4x2 debug RAM. It shares the RAM between two requesters:
- the JTAG-side debug agent, which uses an asynchronous 4-phase req/ack handshake from the tck domain;
- the external host port, which uses a synchronous req/gnt/done handshake.

The block sequences every access as setup, then write strobe or read wait, then response. It is the only driver of the RAM wr/addr/din pins in clk domain.

Parameters:
AWIDTH, 2, RAM address width
DWIDTH, 2, RAM data width
RD_LAT, 1, clk cycles between address setup and sampling ram_dout (>=1)
SYNC_STAGES, 2, flops in dbg_req synchronizer (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
dbg_req  in  1  debug request, 4-phase, async to clk
dbg_wr  in  1  debug write(1)/read(0); stable while dbg_req high
dbg_addr  in  AWIDTH  debug address; stable while dbg_req high
dbg_wdata  in  DWIDTH  debug write data; stable while dbg_req high
dbg_ack  out  1  debug acknowledge, 4-phase
dbg_rdata  out  DWIDTH  debug read data, valid while dbg_ack high
ext_req  in  1  host request level; fields stable until ext_gnt
ext_wr  in  1  host write/read
ext_addr  in  AWIDTH  host address
ext_wdata  in  DWIDTH  host write data
ext_gnt  out  1  one-cycle pulse: host fields captured
ext_done  out  1  one-cycle pulse: host access complete
ext_rdata  out  DWIDTH  host read data, valid with ext_done on reads, held after
ram_wr  out  1  RAM write strobe
ram_addr  out  AWIDTH  RAM address
ram_din  out  DWIDTH  RAM write data
ram_dout  in  DWIDTH  RAM read data
busy  out  1  high in every state except IDLE
dbg_timeout  out  1  sticky handshake-timeout flag (see Optional Feature)

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset, all outputs and captured registers are 0, FSM goes to IDLE, last-winner is ext, and the synchronizer is cleared. Reset mid-access aborts the access; ram_wr drops immediately.
- dbg_req passes through SYNC_STAGES flops to give dbg_req_s. dbg_* fields are sampled directly; they are legal because they are stable under the 4-phase protocol.
- FSM states: IDLE, SETUP, WRITE, RD_WAIT, DONE, DBG_HOLD.
- IDLE: pending = {dbg_req_s & ~dbg_ack, ext_req}. Arbitration is round-robin: if both are pending, the requester that did not win last time wins. The winner's wr/addr/wdata and an owner bit are captured, then go to SETUP.
- SETUP (1 cycle): ram_addr/ram_din are driven from the captured registers and ram_wr=0. ext_gnt=1 in this cycle if owner=ext. Next state is WRITE if wr, else RD_WAIT.
- WRITE (1 cycle): ram_wr=1, then go to DONE.
- RD_WAIT (RD_LAT cycles, counter): on the last cycle, ram_dout is registered into a read buffer. Then go to DONE.
- DONE (1 cycle):
  - owner=ext: ext_done=1; on reads, ext_rdata is updated from the buffer. Go to IDLE.
  - owner=dbg: dbg_rdata is loaded and dbg_ack is set to 1. Go to DBG_HOLD.
- DBG_HOLD: wait for dbg_req_s==0, then clear dbg_ack and return to IDLE.
- ram_addr/ram_din hold their last values outside an access. ram_wr is high only in WRITE.
- Latency is counted from the cycle T in which IDLE sees the request:
  - write: gnt at T+1, ram_wr at T+2, done at T+3;
  - read: done at T+2+RD_LAT.
- ext_req still high after ext_done is treated as a new request on the next IDLE cycle. It is arbitrated against dbg.
- dbg_req dropping before ack is a protocol violation. The access still completes normally.

Optional Feature:
ARB_DBG_TIMEOUT_EN
- Defined: an 8-bit counter runs in DBG_HOLD. If dbg_req_s stays high for 255 cycles, the block clears dbg_ack, sets dbg_timeout (sticky until reset) and returns to IDLE. dbg is then ignored until dbg_req_s has been seen low.
- Undefined: DBG_HOLD waits indefinitely and dbg_timeout is tied 0.

Decomposition:
- Package ram_arb_pkg: state enum arb_state_t, owner enum (OWN_EXT/OWN_DBG), default AWIDTH/DWIDTH, timeout limit constant.
- One sub-module, bit_sync: parameterised SYNC_STAGES flop chain with async reset.

Test Plan:
- Host write: ext_req=1, wr=1, addr=2, wdata=2'b10 at T. Expect ext_gnt at T+1, ram_wr=1 with ram_addr=2 and ram_din=2'b10 at T+2, ext_done at T+3.
- Host read, RD_LAT=1: RAM[2]=2'b10, ext read of addr 2. Expect ext_done at T+3 with ext_rdata=2'b10, and ram_wr stays 0 throughout.
- Debug read: raise dbg_req with addr=1 after writing RAM[1]=2'b01. Expect dbg_ack high with dbg_rdata=2'b01. After dbg_req drops, dbg_ack falls within SYNC_STAGES+1 cycles and busy returns to 0.
- Contention: dbg and ext both pending in IDLE after reset. Expect dbg to win first (last winner is ext), then ext to be granted on the next IDLE. Repeat the contention and expect winners to alternate.
- Reset mid-write: assert rst_n=0 while in WRITE. Expect ram_wr=0 immediately, all outputs 0, and after release a new request completes normally.
- With ARB_DBG_TIMEOUT_EN: hold dbg_req high for 300 cycles after ack. Expect dbg_ack to clear and dbg_timeout=1 after 255 cycles, and ext requests to be served afterwards.

Source files
------------

// File: rtl/ram_access_arb_pkg.sv
// Shared types and constants for the debug-RAM access arbiter.
// Contents: arb_state_t (FSM states), owner_t (access owner),
// default RAM geometry and the debug handshake timeout limit.
package ram_arb_pkg;

  localparam int unsigned AWIDTH_DEF = 2;
  localparam int unsigned DWIDTH_DEF = 2;

  // DBG_HOLD gives up after this many cycles with dbg_req_s still high
  localparam int unsigned TO_LIMIT = 255;
  localparam int unsigned TO_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_WRITE    = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_DONE     = 3'd4,
    ST_DBG_HOLD = 3'd5
  } arb_state_t;

  typedef enum logic {
    OWN_EXT = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

endpackage

// File: rtl/ram_access_arb_bit_sync.sv
// bit_sync: SYNC_STAGES-deep flop chain bringing one async bit into clk.
// Ports: clk, rst_n (async active-low), i_d (async input), o_q (synced).
module bit_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the async bit through the chain; the last flop is the output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_chain <= '0;
    else        r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/ram_access_arb.sv
// ram_access_arb: arbitrates the debug RAM between the JTAG debug agent
// (4-phase req/ack, async to clk) and the host port (req/gnt/done).
// Every access runs SETUP -> WRITE or RD_WAIT -> DONE; debug accesses then
// sit in DBG_HOLD until the agent drops its request.
// Ports: clk/rst_n; i_dbg_* / o_dbg_* debug handshake; i_ext_* / o_ext_*
// host handshake; o_ram_* / i_ram_dout RAM pins; o_busy; o_dbg_timeout.
// Optional macro ARB_DBG_TIMEOUT_EN: abandon DBG_HOLD after TO_LIMIT cycles
// and raise a sticky o_dbg_timeout; when undefined o_dbg_timeout is 0.
module ram_access_arb
  import ram_arb_pkg::*;
#(
  parameter int unsigned AWIDTH      = AWIDTH_DEF,
  parameter int unsigned DWIDTH      = DWIDTH_DEF,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_dbg_req,
  input  logic              i_dbg_wr,
  input  logic [AWIDTH-1:0] i_dbg_addr,
  input  logic [DWIDTH-1:0] i_dbg_wdata,
  output logic              o_dbg_ack,
  output logic [DWIDTH-1:0] o_dbg_rdata,
  input  logic              i_ext_req,
  input  logic              i_ext_wr,
  input  logic [AWIDTH-1:0] i_ext_addr,
  input  logic [DWIDTH-1:0] i_ext_wdata,
  output logic              o_ext_gnt,
  output logic              o_ext_done,
  output logic [DWIDTH-1:0] o_ext_rdata,
  output logic              o_ram_wr,
  output logic [AWIDTH-1:0] o_ram_addr,
  output logic [DWIDTH-1:0] o_ram_din,
  input  logic [DWIDTH-1:0] i_ram_dout,
  output logic              o_busy,
  output logic              o_dbg_timeout
);

  localparam int unsigned RCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic w_dbg_req_s;

  bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dbg_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (i_dbg_req),
    .o_q   (w_dbg_req_s)
  );

  arb_state_t        r_state, w_state;
  owner_t            r_owner, w_owner;
  owner_t            r_last,  w_last;
  logic              r_cap_wr, w_cap_wr;
  logic [RCNT_W-1:0] r_rd_cnt, w_rd_cnt;
  logic              r_ext_gnt, w_ext_gnt;
  logic              r_ext_done, w_ext_done;
  logic [DWIDTH-1:0] r_ext_rdata, w_ext_rdata;
  logic              r_dbg_ack, w_dbg_ack;
  logic [DWIDTH-1:0] r_dbg_rdata, w_dbg_rdata;
  logic              r_ram_wr, w_ram_wr;
  logic [AWIDTH-1:0] r_ram_addr, w_ram_addr;
  logic [DWIDTH-1:0] r_ram_din, w_ram_din;
  logic              r_busy, w_busy;
  logic              w_dbg_pend, w_ext_pend, w_pick_dbg;
`ifdef ARB_DBG_TIMEOUT_EN
  logic [TO_CNT_W-1:0] r_to_cnt, w_to_cnt;
  logic                r_dbg_timeout, w_dbg_timeout;
  logic                r_dbg_block, w_dbg_block;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state;
  end

  // Next state plus next value of every captured/output register.
  // Outputs are registered from the next state so they line up with it;
  // the rdata output registers double as the read buffer.
  always_comb begin
    w_state     = r_state;
    w_owner     = r_owner;
    w_last      = r_last;
    w_cap_wr    = r_cap_wr;
    w_rd_cnt    = r_rd_cnt;
    w_ext_gnt   = 1'b0;
    w_ext_done  = 1'b0;
    w_ext_rdata = r_ext_rdata;
    w_dbg_ack   = r_dbg_ack;
    w_dbg_rdata = r_dbg_rdata;
    w_ram_wr    = 1'b0;
    w_ram_addr  = r_ram_addr;
    w_ram_din   = r_ram_din;
`ifdef ARB_DBG_TIMEOUT_EN
    w_to_cnt      = r_to_cnt;
    w_dbg_timeout = r_dbg_timeout;
    // a timed-out agent stays locked out until its request is seen low
    w_dbg_block   = r_dbg_block & w_dbg_req_s;
    w_dbg_pend    = w_dbg_req_s & ~r_dbg_ack & ~r_dbg_block;
`else
    w_dbg_pend    = w_dbg_req_s & ~r_dbg_ack;
`endif
    w_ext_pend = i_ext_req;
    // round-robin: on contention the loser of the previous round wins
    w_pick_dbg = w_dbg_pend & (~w_ext_pend | (r_last == OWN_EXT));

    case (r_state)
      ST_IDLE: begin
        if (w_dbg_pend || w_ext_pend) begin
          w_state = ST_SETUP;
          if (w_pick_dbg) begin
            w_owner    = OWN_DBG;
            w_cap_wr   = i_dbg_wr;
            w_ram_addr = i_dbg_addr;
            w_ram_din  = i_dbg_wdata;
          end else begin
            w_owner    = OWN_EXT;
            w_cap_wr   = i_ext_wr;
            w_ram_addr = i_ext_addr;
            w_ram_din  = i_ext_wdata;
            w_ext_gnt  = 1'b1;
          end
          w_last = w_owner;
        end
      end
      ST_SETUP: begin
        if (r_cap_wr) begin
          w_state  = ST_WRITE;
          w_ram_wr = 1'b1;
        end else begin
          w_state  = ST_RD_WAIT;
          w_rd_cnt = RCNT_W'(RD_LAT - 1);
        end
      end
      ST_WRITE: begin
        w_state = ST_DONE;
        if (r_owner == OWN_EXT) w_ext_done = 1'b1;
        else                    w_dbg_ack  = 1'b1;
      end
      ST_RD_WAIT: begin
        if (r_rd_cnt == '0) begin
          w_state = ST_DONE;
          if (r_owner == OWN_EXT) begin
            w_ext_done  = 1'b1;
            w_ext_rdata = i_ram_dout;
          end else begin
            w_dbg_ack   = 1'b1;
            w_dbg_rdata = i_ram_dout;
          end
        end else begin
          w_rd_cnt = r_rd_cnt - 1'b1;
        end
      end
      ST_DONE: begin
        if (r_owner == OWN_EXT) begin
          w_state = ST_IDLE;
        end else begin
          w_state = ST_DBG_HOLD;
`ifdef ARB_DBG_TIMEOUT_EN
          w_to_cnt = '0;
`endif
        end
      end
      ST_DBG_HOLD: begin
        if (!w_dbg_req_s) begin
          w_state   = ST_IDLE;
          w_dbg_ack = 1'b0;
`ifdef ARB_DBG_TIMEOUT_EN
        end else if (r_to_cnt == TO_CNT_W'(TO_LIMIT - 1)) begin
          w_state       = ST_IDLE;
          w_dbg_ack     = 1'b0;
          w_dbg_timeout = 1'b1;
          w_dbg_block   = 1'b1;
        end else begin
          w_to_cnt = r_to_cnt + 1'b1;
`endif
        end
      end
      default: w_state = ST_IDLE;
    endcase

    w_busy = (w_state != ST_IDLE);
  end

  // Captured fields and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN_EXT;
      r_last      <= OWN_EXT;
      r_cap_wr    <= 1'b0;
      r_rd_cnt    <= '0;
      r_ext_gnt   <= 1'b0;
      r_ext_done  <= 1'b0;
      r_ext_rdata <= '0;
      r_dbg_ack   <= 1'b0;
      r_dbg_rdata <= '0;
      r_ram_wr    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_owner     <= w_owner;
      r_last      <= w_last;
      r_cap_wr    <= w_cap_wr;
      r_rd_cnt    <= w_rd_cnt;
      r_ext_gnt   <= w_ext_gnt;
      r_ext_done  <= w_ext_done;
      r_ext_rdata <= w_ext_rdata;
      r_dbg_ack   <= w_dbg_ack;
      r_dbg_rdata <= w_dbg_rdata;
      r_ram_wr    <= w_ram_wr;
      r_ram_addr  <= w_ram_addr;
      r_ram_din   <= w_ram_din;
      r_busy      <= w_busy;
    end
  end

`ifdef ARB_DBG_TIMEOUT_EN
  // Timeout counter, sticky flag and post-timeout lockout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt      <= '0;
      r_dbg_timeout <= 1'b0;
      r_dbg_block   <= 1'b0;
    end else begin
      r_to_cnt      <= w_to_cnt;
      r_dbg_timeout <= w_dbg_timeout;
      r_dbg_block   <= w_dbg_block;
    end
  end
  assign o_dbg_timeout = r_dbg_timeout;
`else
  assign o_dbg_timeout = 1'b0;
`endif

  assign o_dbg_ack   = r_dbg_ack;
  assign o_dbg_rdata = r_dbg_rdata;
  assign o_ext_gnt   = r_ext_gnt;
  assign o_ext_done  = r_ext_done;
  assign o_ext_rdata = r_ext_rdata;
  assign o_ram_wr    = r_ram_wr;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_din   = r_ram_din;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_ram_access_arb.sv
// Self-checking bench for ram_access_arb: table of host accesses against a
// 4x2 RAM model, then debug read, reset mid-write, contention and timeout.
module tb_ram_access_arb;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 2;
  localparam int unsigned SS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dbg_req = 1'b0, dbg_wr = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          ext_req = 1'b0, ext_wr = 1'b0;
  logic [AW-1:0] ext_addr = '0;
  logic [DW-1:0] ext_wdata = '0;
  logic          ext_gnt, ext_done;
  logic [DW-1:0] ext_rdata;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          busy, dbg_timeout;

  logic [DW-1:0] mem [0:3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_access_arb #(.AWIDTH(AW), .DWIDTH(DW), .RD_LAT(1), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_dbg_req(dbg_req), .i_dbg_wr(dbg_wr), .i_dbg_addr(dbg_addr),
    .i_dbg_wdata(dbg_wdata), .o_dbg_ack(dbg_ack), .o_dbg_rdata(dbg_rdata),
    .i_ext_req(ext_req), .i_ext_wr(ext_wr), .i_ext_addr(ext_addr),
    .i_ext_wdata(ext_wdata), .o_ext_gnt(ext_gnt), .o_ext_done(ext_done),
    .o_ext_rdata(ext_rdata), .o_ram_wr(ram_wr), .o_ram_addr(ram_addr),
    .o_ram_din(ram_din), .i_ram_dout(ram_dout), .o_busy(busy),
    .o_dbg_timeout(dbg_timeout)
  );

  // RAM model: synchronous write, asynchronous read
  always @(posedge clk) if (ram_wr) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One host access; request seen at T, gnt T+1, strobe/wait T+2, done T+3
  task automatic ext_access(input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd);
    @(negedge clk);
    ext_req = 1'b1; ext_wr = wr; ext_addr = addr; ext_wdata = wdata;
    @(negedge clk);
    chk("ext_gnt_t1", ext_gnt, 1);
    chk("busy_t1", busy, 1);
    chk("ram_wr_t1", ram_wr, 0);
    ext_req = 1'b0;
    @(negedge clk);
    chk("ram_wr_t2", ram_wr, wr);
    chk("ram_addr_t2", ram_addr, addr);
    if (wr) chk("ram_din_t2", ram_din, wdata);
    chk("ext_done_t2", ext_done, 0);
    @(negedge clk);
    chk("ext_done_t3", ext_done, 1);
    chk("ram_wr_t3", ram_wr, 0);
    if (!wr) chk("ext_rdata_t3", ext_rdata, exp_rd);
    @(negedge clk);
    chk("ext_done_t4", ext_done, 0);
    chk("busy_t4", busy, 0);
  endtask

  // Wait for whichever of ext_gnt / dbg_ack comes first: 0=ext 1=dbg -1=none
  task automatic wait_winner(output int who);
    who = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ext_gnt) begin who = 0; break; end
      if (dbg_ack) begin who = 1; break; end
    end
  endtask

  task automatic wait_gnt(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ext_gnt) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ack(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg_ack) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int   who;
    int   n;
    logic ok;

    vecs[0] = '{1'b1, 2'd2, 2'b10, 2'b00};
    vecs[1] = '{1'b0, 2'd2, 2'b00, 2'b10};
    vecs[2] = '{1'b1, 2'd1, 2'b01, 2'b00};
    vecs[3] = '{1'b1, 2'd0, 2'b11, 2'b00};
    vecs[4] = '{1'b1, 2'd3, 2'b00, 2'b00};
    vecs[5] = '{1'b0, 2'd0, 2'b00, 2'b11};
    vecs[6] = '{1'b0, 2'd1, 2'b00, 2'b01};
    vecs[7] = '{1'b0, 2'd3, 2'b00, 2'b00};
    for (int i = 0; i < 4; i++) mem[i] = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_dbg_ack", dbg_ack, 0);
    chk("rst_ext_gnt", ext_gnt, 0);
    chk("rst_ext_rdata", ext_rdata, 0);
    chk("rst_dbg_timeout", dbg_timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // host access table
    for (int i = 0; i < 8; i++)
      ext_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

    // debug read of RAM[1]=01, then 4-phase release
    @(negedge clk);
    dbg_wr = 1'b0; dbg_addr = 2'd1; dbg_req = 1'b1;
    wait_ack(ok);
    chk("dbg_ack_rise", ok, 1);
    chk("dbg_rdata", dbg_rdata, 2'b01);
    chk("dbg_busy_hold", busy, 1);
    dbg_req = 1'b0;
    n = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (!dbg_ack) begin n = i; break; end
    end
    chk("dbg_ack_fall_seen", (n != 0), 1);
    chk("dbg_ack_fall_bound", (n <= SS + 1), 1);
    chk("dbg_busy_idle", busy, 0);
    chk("dbg_timeout_low", dbg_timeout, 0);

    // reset while in WRITE: strobe drops at once, RAM[0] untouched
    @(negedge clk);
    ext_req = 1'b1; ext_wr = 1'b1; ext_addr = 2'd0; ext_wdata = 2'b01;
    @(negedge clk);
    ext_req = 1'b0;
    @(negedge clk);
    chk("midwr_ram_wr_before", ram_wr, 1);
    rst_n = 1'b0;
    #1;
    chk("midwr_ram_wr", ram_wr, 0);
    chk("midwr_busy", busy, 0);
    chk("midwr_ram_addr", ram_addr, 0);
    chk("midwr_ram_din", ram_din, 0);
    chk("midwr_ext_done", ext_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ext_access(1'b0, 2'd0, 2'b00, 2'b11);
    ext_access(1'b1, 2'd0, 2'b01, 2'b00);
    ext_access(1'b0, 2'd0, 2'b00, 2'b01);

    // contention from reset: last winner is ext, so dbg goes first
    do_reset();
    dbg_wr = 1'b0; dbg_addr = 2'd1; dbg_req = 1'b1;
    ext_wr = 1'b0; ext_addr = 2'd2;
    @(negedge clk);
    @(negedge clk);
    ext_req = 1'b1;
    wait_winner(who);
    chk("cont0_winner_dbg", who, 1);
    dbg_req = 1'b0;
    wait_gnt(ok);
    chk("cont0_ext_next", ok, 1);
    // ext_req stays high; re-raise dbg so both are pending again
    for (int r = 1; r <= 2; r++) begin
      dbg_req = 1'b1;
      wait_winner(who);
      chk("contN_winner_dbg", who, 1);
      chk("contN_dbg_rdata", dbg_rdata, 2'b01);
      dbg_req = 1'b0;
      wait_gnt(ok);
      chk("contN_ext_next", ok, 1);
    end
    ext_req = 1'b0;
    repeat (6) @(negedge clk);
    chk("cont_busy_idle", busy, 0);

`ifdef ARB_DBG_TIMEOUT_EN
    // hold dbg_req high after ack: ack clears and sticky flag sets
    @(negedge clk);
    dbg_wr = 1'b0; dbg_addr = 2'd1; dbg_req = 1'b1;
    wait_ack(ok);
    chk("to_ack_rise", ok, 1);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (!dbg_ack) begin n = i; break; end
    end
    chk("to_ack_cleared", (n >= 250 && n <= 260), 1);
    chk("to_flag", dbg_timeout, 1);
    ext_access(1'b0, 2'd1, 2'b00, 2'b01);
    chk("to_flag_sticky", dbg_timeout, 1);
    dbg_req = 1'b0;
    repeat (4) @(negedge clk);
`else
    chk("no_to_flag", dbg_timeout, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
